// File: rtl/sram_burst_reader.sv
// Burst read engine for the byte-wide activation SRAM: issues one byte read per cycle,
// packs returned bytes little-endian into 32-bit words and streams them out through a 2-entry FIFO.
module sram_burst_reader #(
  parameter int N_ENTRIES = 10240,
  parameter int LEN_W     = 14,
  parameter int AW        = $clog2(N_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset_n,
  // Both streams: a transfer happens on a rising edge where valid && ready; a producer holds
  // valid and its payload steady until that edge, and ready never waits on valid.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             sram_en_o,
  output logic [AW-1:0]    sram_addr_o,
  input  logic [7:0]       sram_data_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_strb,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Issue side
  logic [AW-1:0]    addr_q;
  logic [LEN_W-1:0] left_q;
  logic [1:0]       lane_q;

  // Byte in flight through the SRAM (one cycle of read latency)
  logic             rd_pend_q;
  logic             rd_cmpl_q;
  logic             rd_final_q;
  logic [1:0]       rd_lane_q;

  logic [31:0]      pack_q;

  // Output FIFO
  logic [31:0]      fifo_data [2];
  logic [3:0]       fifo_strb [2];
  logic             fifo_last [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  logic             done_q;

  logic             cmd_fire;
  logic             len_zero;
  logic             issue;
  logic             issue_last;
  logic             issue_cmpl;
  logic             push;
  logic             push_ok;
  logic             pop;
  logic             head_last;
  logic [31:0]      push_data;
  logic [3:0]       push_strb;
  logic [AW-1:0]    addr_next;

  assign len_zero   = (cmd_len == '0);
  assign cmd_fire   = cmd_valid && (state_q == IDLE);
  assign issue_last = (left_q == LEN_W'(1));
  assign issue_cmpl = (lane_q == 2'd3) || issue_last;
  assign push       = rd_pend_q && rd_cmpl_q;
  assign push_ok    = push && ((count_q != 2'd2) || pop);
  assign pop        = out_valid && out_ready;
  assign head_last  = fifo_last[rd_ptr_q];
  assign addr_next  = (addr_q == AW'(N_ENTRIES - 1)) ? '0 : addr_q + AW'(1);

  // An issue that would complete a word is held back whenever that word could meet a full FIFO.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire && !len_zero) state_d = READ;
      end
      READ: begin
        issue = !(issue_cmpl && ((count_q == 2'd2) || ((count_q == 2'd1) && push)));
        if (issue && issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Word being completed: packer lanes below the incoming byte plus the byte itself.
  always_comb begin
    push_data = pack_q;
    push_data[{rd_lane_q, 3'b000} +: 8] = sram_data_i;
    push_strb = 4'hF;
    unique case (rd_lane_q)
      2'd0:    push_strb = 4'h1;
      2'd1:    push_strb = 4'h3;
      2'd2:    push_strb = 4'h7;
      default: push_strb = 4'hF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      left_q     <= '0;
      lane_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_cmpl_q  <= 1'b0;
      rd_final_q <= 1'b0;
      rd_lane_q  <= '0;
      pack_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q    <= (cmd_fire && len_zero) || ((state_q == DRAIN) && pop && head_last);
      rd_pend_q <= issue;
      if (issue) begin
        rd_lane_q  <= lane_q;
        rd_cmpl_q  <= issue_cmpl;
        rd_final_q <= issue_last;
      end
      if (cmd_fire && !len_zero) begin
        addr_q <= cmd_addr;
        left_q <= cmd_len;
        lane_q <= '0;
      end else if (issue) begin
        left_q <= left_q - LEN_W'(1);
        lane_q <= lane_q + 2'd1;
        // The address stays on the final byte once the burst has been fully issued.
        if (!issue_last) addr_q <= addr_next;
      end
      if (rd_pend_q) begin
        if (rd_cmpl_q) pack_q <= '0;
        else           pack_q[{rd_lane_q, 3'b000} +: 8] <= sram_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_strb[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        fifo_data[wr_ptr_q] <= push_data;
        fifo_strb[wr_ptr_q] <= push_strb;
        fifo_last[wr_ptr_q] <= rd_final_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid   = (count_q != 2'd0);
  assign out_data    = out_valid ? fifo_data[rd_ptr_q] : '0;
  assign out_strb    = out_valid ? fifo_strb[rd_ptr_q] : '0;
  assign out_last    = out_valid ? fifo_last[rd_ptr_q] : 1'b0;
  assign sram_en_o   = issue;
  assign sram_addr_o = addr_q;
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader: SRAM model, scoreboard of expected words,
// timing, wrap, backpressure, reset and command-hold scenarios.
module tb_sram_burst_reader;

  localparam int N_ENTRIES = 10240;
  localparam int LEN_W     = 14;
  localparam int AW        = 14;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             sram_en_o;
  logic [AW-1:0]    sram_addr_o;
  logic [7:0]       sram_data_i = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [3:0]       out_strb;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  sram_burst_reader #(.N_ENTRIES(N_ENTRIES), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .sram_en_o(sram_en_o), .sram_addr_o(sram_addr_o), .sram_data_i(sram_data_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_strb(out_strb), .out_last(out_last),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- SRAM model ----------------
  logic [7:0] mem [N_ENTRIES];
  always @(posedge clk) if (sram_en_o) sram_data_i <= mem[sram_addr_o];

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];
  int          pop_cyc_q[$];
  logic [AW-1:0] addr_seen[$];
  int          en_cnt = 0;
  int          word_cnt = 0;
  int          last_pop_cnt = 0;
  bit          stall_q = 1'b0;
  logic [36:0] held;

  task automatic model_push(input int a, input int l);
    logic [31:0] w;
    logic [3:0]  s;
    int          lane;
    w = '0;
    s = '0;
    for (int i = 0; i < l; i++) begin
      lane = i % 4;
      w[lane*8 +: 8] = mem[(a + i) % N_ENTRIES];
      s[lane] = 1'b1;
      if (lane == 3 || i == l - 1) begin
        exp_q.push_back({(i == l - 1), s, w});
        w = '0;
        s = '0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (sram_en_o) begin
        en_cnt++;
        addr_seen.push_back(sram_addr_o);
      end
      if (stall_q) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_word", {out_last, out_strb, out_data}, held);
      end
      stall_q = out_valid && !out_ready;
      held    = {out_last, out_strb, out_data};
      if (out_valid && out_ready) begin
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_word: observed %0h expected none", {out_last, out_strb, out_data});
        end
        if (exp_q.size() > 0) chk("word", {out_last, out_strb, out_data}, exp_q.pop_front());
        pop_cyc_q.push_back(edge_cnt);
        word_cnt++;
        if (out_last) last_pop_cnt = edge_cnt;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int ready_mode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 9) < 3);
      else                      out_ready = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int a, input int l, input bit keep_valid, output int acc);
    int g;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = AW'(a);
    cmd_len   = LEN_W'(l);
    g = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_accept_in_time", (g < 2000), 1);
    @(posedge clk);
    #1;
    acc = edge_cnt;
    model_push(a, l);
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int d);
    int g;
    g = 0;
    @(negedge clk);
    while (done !== 1'b1 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("done_in_time", (g < 3000), 1);
    d = edge_cnt;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_zero"}, {busy, done, out_valid, sram_en_o, sram_addr_o, out_data, out_strb,
                         out_last, state_dbg}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int acc, d, bad, g;

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    for (int i = 0; i < N_ENTRIES; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'(i + 1);

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    #2 reset_n = 1'b1;

    // 1: len=8 at 0x10, words at cycles 6 and 10, done after last handshake
    pop_cyc_q.delete();
    send_cmd(16, 8, 1'b0, acc);
    chk("t1_busy", busy, 1);
    wait_done(d);
    chk("t1_word0_cycle", pop_cyc_q[0], acc + 5);
    chk("t1_word1_cycle", pop_cyc_q[1], acc + 9);
    chk("t1_done_after_last", d, last_pop_cnt + 1);
    chk("t1_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // 2a: len=6 partial tail
    send_cmd(16, 6, 1'b0, acc);
    wait_done(d);
    chk("t2_drained", exp_q.size(), 0);

    // 2b: len=0 accepted, no access, done the cycle after acceptance
    en_cnt = 0;
    word_cnt = 0;
    send_cmd(100, 0, 1'b0, acc);
    wait_done(d);
    chk("t2_len0_done_cycle", d, acc);
    chk("t2_len0_no_access", en_cnt, 0);
    @(negedge clk);
    chk("t2_len0_no_words", word_cnt, 0);

    // 2c: len=2 latency, word at cycle 4
    pop_cyc_q.delete();
    send_cmd(40, 2, 1'b0, acc);
    wait_done(d);
    chk("t2_len2_cycle", pop_cyc_q[0], acc + 3);
    chk("t2_len2_drained", exp_q.size(), 0);

    // 3: address wrap
    addr_seen.delete();
    send_cmd(N_ENTRIES - 2, 4, 1'b0, acc);
    wait_done(d);
    chk("t3_addr_count", addr_seen.size(), 4);
    chk("t3_addr0", addr_seen[0], 10238);
    chk("t3_addr1", addr_seen[1], 10239);
    chk("t3_addr2", addr_seen[2], 0);
    chk("t3_addr3", addr_seen[3], 1);
    chk("t3_drained", exp_q.size(), 0);

    // 4: random backpressure on a 32-byte burst
    ready_mode = 1;
    en_cnt = 0;
    word_cnt = 0;
    send_cmd(1000, 32, 1'b0, acc);
    wait_done(d);
    chk("t4_en_cycles", en_cnt, 32);
    chk("t4_word_count", word_cnt, 8);
    chk("t4_drained", exp_q.size(), 0);
    ready_mode = 0;

    // 5: reset after 5 bytes issued, then a clean burst
    en_cnt = 0;
    send_cmd(512, 16, 1'b0, acc);
    g = 0;
    while (en_cnt < 5 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("t5_reached_5_bytes", (g < 200), 1);
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    exp_q.delete();
    @(negedge clk);
    check_idle_outputs("t5_next_cycle");
    #2 reset_n = 1'b1;
    en_cnt = 0;
    word_cnt = 0;
    send_cmd(768, 4, 1'b0, acc);
    wait_done(d);
    chk("t5_en_cycles", en_cnt, 4);
    chk("t5_word_count", word_cnt, 1);
    chk("t5_drained", exp_q.size(), 0);

    // 6: cmd_valid held through a burst; second command waits for done
    send_cmd(2000, 4, 1'b1, acc);
    cmd_addr = AW'(3000);
    cmd_len  = LEN_W'(5);
    bad = 0;
    g = 0;
    @(negedge clk);
    while (done !== 1'b1 && g < 500) begin
      if (cmd_ready !== 1'b0) bad++;
      @(negedge clk);
      g++;
    end
    chk("t6_ready_low_while_busy", bad, 0);
    chk("t6_ready_at_done", cmd_ready, 1);
    @(posedge clk);
    #1;
    model_push(3000, 5);
    cmd_valid = 1'b0;
    chk("t6_second_accepted", busy, 1);
    wait_done(d);
    chk("t6_drained", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
